qbus_mem_responder: RTL and testbench

//  Bus responder (target end) for the CPU's SYNC/DIN/DOUT/WTBT/RPLY handshake.
//  It decodes an address window and drives a synchronous single-port RAM
//  (1-cycle read latency). It returns RPLY after a programmable number of

---
 rtl/qbus_mem_responder.sv | 153 +++++++++++++++
 tb/tb_qbus_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbus_mem_responder.sv
// Bus target for the SYNC/DIN/DOUT/WTBT/RPLY handshake, fronting a synchronous
// single-port RAM with a programmable number of wait states before the access.
module qbus_mem_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'o100000,
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 1,
  parameter bit          READ_ONLY   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [15:0]           addr_i,
  input  logic [15:0]           data_i,
  input  logic                  SYNC,
  input  logic                  DIN,
  input  logic                  DOUT,
  input  logic                  WTBT,
  output logic                  RPLY,
  output logic [15:0]           data_o,
  output logic                  sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic [1:0]            mem_be,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [15:0]           mem_rdata,
  output logic [2:0]            o_dbg_state
);

  // Handshake: the master raises SYNC with a valid address plus exactly one of
  // DIN/DOUT; the responder answers with RPLY and holds it (with read data)
  // until the master has released SYNC, DIN and DOUT.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_LATCH  = 3'd3,
    S_REPLY  = 3'd4
  } state_t;

  localparam logic [16:0] LIMIT = {1'b0, BASE_ADDR} + (17'd1 << (ADDR_WIDTH + 1));
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  r_dir;
  logic                  r_rply;
  logic                  w_rply_nxt;
  logic [15:0]           r_data;
  logic [15:0]           w_data_nxt;
  logic                  r_we;
  logic                  w_we_nxt;
  logic                  r_re;
  logic                  w_re_nxt;
  logic                  w_accept;
  logic                  w_hit;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [1:0]            w_be;

  assign w_hit   = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_i} < LIMIT);
  assign sel     = SYNC & w_hit;
  assign w_index = ADDR_WIDTH'((addr_i - BASE_ADDR) >> 1);
  // Byte writes pick their lane from address bit 0; reads and word writes use both.
  assign w_be    = (DOUT && WTBT) ? (addr_i[0] ? 2'b10 : 2'b01) : 2'b11;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rply_nxt  = r_rply;
    w_data_nxt  = r_data;
    w_we_nxt    = 1'b0;
    w_re_nxt    = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sel && (DIN ^ DOUT)) begin
          w_accept  = 1'b1;
          w_cnt_nxt = WS;
          if (WS == 4'd0) begin
            w_state_nxt = S_ACCESS;
            w_we_nxt    = DOUT && !READ_ONLY;
            w_re_nxt    = DIN;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!SYNC) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = S_ACCESS;
          w_we_nxt    = r_dir && !READ_ONLY;
          w_re_nxt    = !r_dir;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      // The strobe is already on the RAM during ACCESS, so an abort here still writes.
      S_ACCESS: w_state_nxt = SYNC ? S_LATCH : S_IDLE;
      S_LATCH: begin
        if (!r_dir) w_data_nxt = mem_rdata;
        w_rply_nxt  = 1'b1;
        w_state_nxt = S_REPLY;
      end
      S_REPLY: begin
        if (!SYNC && !DIN && !DOUT) begin
          w_rply_nxt  = 1'b0;
          w_data_nxt  = 16'h0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_dir     <= 1'b0;
      r_rply    <= 1'b0;
      r_data    <= 16'h0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 16'h0;
      mem_be    <= 2'b00;
    end else if (ce) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rply  <= w_rply_nxt;
      r_data  <= w_data_nxt;
      r_we    <= w_we_nxt;
      r_re    <= w_re_nxt;
      if (w_accept) begin
        r_dir     <= DOUT;
        mem_addr  <= w_index;
        mem_wdata <= data_i;
        mem_be    <= w_be;
      end
    end
  end

  assign RPLY        = r_rply;
  assign data_o      = r_data;
  assign mem_we      = r_we;
  assign mem_re      = r_re;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_qbus_mem_responder.sv
// Directed bench: three responders (1 wait state; 4 wait states; 0 wait states
// read-only) share one bus, each with its own RAM model and clock enable.
module tb_qbus_mem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  ce_v;
  logic [15:0] addr_i, data_i;
  logic        SYNC, DIN, DOUT, WTBT;

  logic        rply      [3];
  logic [15:0] data_o    [3];
  logic        sel       [3];
  logic [9:0]  mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic [1:0]  mem_be    [3];
  logic        mem_we    [3];
  logic        mem_re    [3];
  logic [2:0]  dbg       [3];

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  logic [2:0] ce_en;
  bit         div3;
  int         phase;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [15:0] ram [1024];
    logic [15:0] rdata;

    qbus_mem_responder #(
      .BASE_ADDR  (16'o100000),
      .ADDR_WIDTH (10),
      .WAIT_STATES(g == 1 ? 4 : (g == 0 ? 1 : 0)),
      .READ_ONLY  (g == 2)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ce         (ce_v[g]),
      .addr_i     (addr_i),
      .data_i     (data_i),
      .SYNC       (SYNC),
      .DIN        (DIN),
      .DOUT       (DOUT),
      .WTBT       (WTBT),
      .RPLY       (rply[g]),
      .data_o     (data_o[g]),
      .sel        (sel[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_be     (mem_be[g]),
      .mem_we     (mem_we[g]),
      .mem_re     (mem_re[g]),
      .mem_rdata  (rdata),
      .o_dbg_state(dbg[g])
    );

    // RAM model: word i powers up as 16'h1000+i, one-cycle read latency.
    always @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < 1024; i++) ram[i] <= 16'h1000 + 16'(i);
        rdata <= 16'h0;
      end else if (ce_v[g]) begin
        if (mem_we[g]) begin
          if (mem_be[g][0]) ram[mem_addr[g]][7:0]  <= mem_wdata[g][7:0];
          if (mem_be[g][1]) ram[mem_addr[g]][15:8] <= mem_wdata[g][15:8];
        end
        if (mem_re[g]) rdata <= ram[mem_addr[g]];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_edge(output bit was_ce);
    if (div3) ce_v = ((phase % 3) == 0) ? ce_en : 3'b000;
    else      ce_v = ce_en;
    phase++;
    was_ce = |ce_v;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    SYNC = 1'b0; DIN = 1'b0; DOUT = 1'b0; WTBT = 1'b0;
  endtask

  task automatic release_bus(input int inst, input string tag);
    bit c;
    int k;
    bus_idle();
    k = 0;
    while (rply[inst] && k < 40) begin
      next_edge(c);
      k++;
    end
    chk({tag, "_rel_rply"}, 32'(rply[inst]), 32'd0);
    chk({tag, "_rel_data"}, 32'(data_o[inst]), 32'd0);
    chk({tag, "_rel_state"}, 32'(dbg[inst]), 32'd0);
  endtask

  task automatic xfer(input int inst, input logic [15:0] addr, input bit wr, input bit wtbt,
                      input logic [15:0] wdata, input logic [15:0] exp_rd, input int exp_lat,
                      input int exp_we, input logic [1:0] exp_be, input bit do_release,
                      input string tag);
    int n, we_p, re_p;
    bit c, prev_we, prev_re, got, zero_ok;
    logic [9:0]  wa;
    logic [1:0]  wbe;
    logic [15:0] wd, exp_d;
    n = 0; we_p = 0; re_p = 0; prev_we = 0; prev_re = 0; got = 0; zero_ok = 1;
    wa = '0; wbe = '0; wd = '0;
    exp_q.push_back(wr ? 16'h0 : exp_rd);
    addr_i = addr; data_i = wr ? wdata : 16'h0; WTBT = wtbt;
    DIN = !wr; DOUT = wr; SYNC = 1'b1;
    #1;
    chk({tag, "_sel"}, 32'(sel[inst]), 32'd1);
    for (int k = 0; k < 60 && !got; k++) begin
      next_edge(c);
      if (c) n++;
      if (mem_we[inst] && !prev_we) begin
        we_p++; wa = mem_addr[inst]; wbe = mem_be[inst]; wd = mem_wdata[inst];
      end
      if (mem_re[inst] && !prev_re) re_p++;
      prev_we = mem_we[inst];
      prev_re = mem_re[inst];
      if (rply[inst]) got = 1;
      else if (data_o[inst] != 16'h0) zero_ok = 0;
    end
    exp_d = exp_q.pop_front();
    chk({tag, "_rply"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(n - 1), 32'(exp_lat));
    chk({tag, "_data"}, 32'(data_o[inst]), 32'(exp_d));
    chk({tag, "_zero_before_rply"}, 32'(zero_ok), 32'd1);
    chk({tag, "_we_pulses"}, 32'(we_p), 32'(exp_we));
    chk({tag, "_re_pulses"}, 32'(re_p), wr ? 32'd0 : 32'd1);
    if (we_p > 0) begin
      chk({tag, "_waddr"}, 32'(wa), 32'((addr - 16'o100000) >> 1));
      chk({tag, "_wbe"}, 32'(wbe), 32'(exp_be));
      chk({tag, "_wdata"}, 32'(wd), 32'(wdata));
    end
    if (do_release) release_bus(inst, tag);
  endtask

  task automatic no_response(input int inst, input logic [15:0] addr, input bit rd, input bit wr,
                             input bit exp_sel, input string tag);
    bit c, seen;
    addr_i = addr; data_i = 16'h5555; WTBT = 1'b0; DIN = rd; DOUT = wr; SYNC = 1'b1;
    #1;
    chk({tag, "_sel"}, 32'(sel[inst]), 32'(exp_sel));
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      next_edge(c);
      if (rply[inst] || mem_we[inst] || mem_re[inst]) seen = 1;
    end
    chk({tag, "_no_activity"}, 32'(seen), 32'd0);
    chk({tag, "_state"}, 32'(dbg[inst]), 32'd0);
    bus_idle();
    next_edge(c);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit c, seen;
    reset_n = 1'b0; ce_en = 3'b000; div3 = 0; phase = 0; ce_v = 3'b000;
    addr_i = 16'h0; data_i = 16'h0;
    bus_idle();
    for (int k = 0; k < 3; k++) next_edge(c);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_rply%0d", i), 32'(rply[i]), 32'd0);
      chk($sformatf("reset_data%0d", i), 32'(data_o[i]), 32'd0);
      chk($sformatf("reset_state%0d", i), 32'(dbg[i]), 32'd0);
      chk($sformatf("reset_strobes%0d", i), 32'({mem_we[i], mem_re[i]}), 32'd0);
    end
    reset_n = 1'b1;
    next_edge(c);

    // Instance 0: one wait state
    ce_en = 3'b001;
    xfer(0, 16'o100002, 1, 0, 16'o123456, 16'h0, 3, 1, 2'b11, 1, "w_word");
    xfer(0, 16'o100002, 0, 0, 16'h0, 16'o123456, 3, 0, 2'b11, 1, "r_word");
    xfer(0, 16'o100005, 1, 1, 16'hA500, 16'h0, 3, 1, 2'b10, 1, "w_byte_hi");
    xfer(0, 16'o100004, 0, 0, 16'h0, 16'hA502, 3, 0, 2'b11, 1, "r_byte_hi");
    xfer(0, 16'o100006, 1, 1, 16'h005A, 16'h0, 3, 1, 2'b01, 1, "w_byte_lo");
    xfer(0, 16'o100005, 0, 1, 16'h0, 16'hA502, 3, 0, 2'b11, 1, "r_byte_full");
    xfer(0, 16'o100006, 0, 0, 16'h0, 16'h105A, 3, 0, 2'b11, 1, "r_byte_lo");
    xfer(0, 16'o103776, 0, 0, 16'h0, 16'h13FF, 3, 0, 2'b11, 1, "r_top_word");
    xfer(0, 16'o100000, 0, 0, 16'h0, 16'h1000, 3, 0, 2'b11, 1, "r_base_word");
    no_response(0, 16'o077776, 1, 0, 0, "miss_below");
    no_response(0, 16'o104000, 0, 1, 0, "miss_above");
    no_response(0, 16'o100000, 1, 1, 1, "din_and_dout");

    // RPLY and data are held while SYNC stays high
    xfer(0, 16'o100002, 0, 0, 16'h0, 16'o123456, 3, 0, 2'b11, 0, "hold");
    DIN = 1'b0;
    for (int k = 0; k < 4; k++) next_edge(c);
    chk("hold_rply", 32'(rply[0]), 32'd1);
    chk("hold_data", 32'(data_o[0]), 32'(16'o123456));
    chk("hold_state", 32'(dbg[0]), 32'd4);
    release_bus(0, "hold");

    // Instance 1: four wait states, abort from WAIT
    ce_en = 3'b010;
    addr_i = 16'o100020; data_i = 16'hDEAD; WTBT = 1'b0; DIN = 1'b0; DOUT = 1'b1; SYNC = 1'b1;
    next_edge(c);
    next_edge(c);
    chk("abort_in_wait", 32'(dbg[1]), 32'd1);
    bus_idle();
    seen = 0;
    next_edge(c);
    chk("abort_idle", 32'(dbg[1]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      next_edge(c);
      if (rply[1] || mem_we[1]) seen = 1;
    end
    chk("abort_no_activity", 32'(seen), 32'd0);
    xfer(1, 16'o100020, 0, 0, 16'h0, 16'h1008, 6, 0, 2'b11, 1, "abort_unwritten");
    xfer(1, 16'o100022, 1, 0, 16'h4321, 16'h0, 6, 1, 2'b11, 1, "ws4_write");
    xfer(1, 16'o100022, 0, 0, 16'h0, 16'h4321, 6, 0, 2'b11, 1, "ws4_read");

    // Instance 2: read-only, zero wait states, ce one edge in three
    ce_en = 3'b100; div3 = 1; phase = 1;
    xfer(2, 16'o100040, 1, 0, 16'hBEEF, 16'h0, 2, 0, 2'b11, 1, "ro_write");
    xfer(2, 16'o100040, 0, 0, 16'h0, 16'h1010, 2, 0, 2'b11, 1, "ro_read");
    div3 = 0;

    // Reset while in REPLY, with ce low
    ce_en = 3'b001;
    xfer(0, 16'o100002, 0, 0, 16'h0, 16'o123456, 3, 0, 2'b11, 0, "pre_reset");
    reset_n = 1'b0; ce_en = 3'b000;
    next_edge(c);
    chk("rst_reply_rply", 32'(rply[0]), 32'd0);
    chk("rst_reply_data", 32'(data_o[0]), 32'd0);
    chk("rst_reply_state", 32'(dbg[0]), 32'd0);
    chk("rst_reply_be", 32'(mem_be[0]), 32'd0);
    bus_idle();
    next_edge(c);
    reset_n = 1'b1;
    next_edge(c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
